// File: rtl/rot_pkg.sv
// Shared definitions for the rotation controller: Q9.6 constants, HID keycodes
// and the matrix-update state machine encoding.
package rot_pkg;

    localparam int                 FRAC_BITS = 6;
    localparam logic signed [15:0] ONE       = 16'sd64;

    localparam logic [7:0] KEY_CCW = 8'h14;
    localparam logic [7:0] KEY_CW  = 8'h08;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_COS,
        ADDR_SIN,
        CAP_SIN,
        COMMIT
    } rot_state_t;

endpackage

// File: rtl/sincos_rom.sv
// First-quadrant sine table, T[k] = round(64*sin(2*pi*k/256)) for k = 0..64.
// Synchronous read with one cycle of latency and no reset on the data path.
module sincos_rom (
    input  logic       i_clk,
    input  logic [6:0] i_addr,
    output logic [7:0] o_data
);

    logic [7:0] r_data;

    always_ff @(posedge i_clk) begin
        case (i_addr)
            7'd0:  r_data <= 8'd0;   7'd1:  r_data <= 8'd2;   7'd2:  r_data <= 8'd3;
            7'd3:  r_data <= 8'd5;   7'd4:  r_data <= 8'd6;   7'd5:  r_data <= 8'd8;
            7'd6:  r_data <= 8'd9;   7'd7:  r_data <= 8'd11;  7'd8:  r_data <= 8'd12;
            7'd9:  r_data <= 8'd14;  7'd10: r_data <= 8'd16;  7'd11: r_data <= 8'd17;
            7'd12: r_data <= 8'd19;  7'd13: r_data <= 8'd20;  7'd14: r_data <= 8'd22;
            7'd15: r_data <= 8'd23;  7'd16: r_data <= 8'd24;  7'd17: r_data <= 8'd26;
            7'd18: r_data <= 8'd27;  7'd19: r_data <= 8'd29;  7'd20: r_data <= 8'd30;
            7'd21: r_data <= 8'd32;  7'd22: r_data <= 8'd33;  7'd23: r_data <= 8'd34;
            7'd24: r_data <= 8'd36;  7'd25: r_data <= 8'd37;  7'd26: r_data <= 8'd38;
            7'd27: r_data <= 8'd39;  7'd28: r_data <= 8'd41;  7'd29: r_data <= 8'd42;
            7'd30: r_data <= 8'd43;  7'd31: r_data <= 8'd44;  7'd32: r_data <= 8'd45;
            7'd33: r_data <= 8'd46;  7'd34: r_data <= 8'd47;  7'd35: r_data <= 8'd48;
            7'd36: r_data <= 8'd49;  7'd37: r_data <= 8'd50;  7'd38: r_data <= 8'd51;
            7'd39: r_data <= 8'd52;  7'd40: r_data <= 8'd53;  7'd41: r_data <= 8'd54;
            7'd42: r_data <= 8'd55;  7'd43: r_data <= 8'd56;  7'd44: r_data <= 8'd56;
            7'd45: r_data <= 8'd57;  7'd46: r_data <= 8'd58;  7'd47: r_data <= 8'd59;
            7'd48: r_data <= 8'd59;  7'd49: r_data <= 8'd60;  7'd50: r_data <= 8'd60;
            7'd51: r_data <= 8'd61;  7'd52: r_data <= 8'd61;  7'd53: r_data <= 8'd62;
            7'd54: r_data <= 8'd62;  7'd55: r_data <= 8'd62;  7'd56: r_data <= 8'd63;
            7'd57: r_data <= 8'd63;  7'd58: r_data <= 8'd63;  7'd59: r_data <= 8'd64;
            7'd60: r_data <= 8'd64;  7'd61: r_data <= 8'd64;  7'd62: r_data <= 8'd64;
            7'd63: r_data <= 8'd64;  7'd64: r_data <= 8'd64;
            default: r_data <= 8'd0;
        endcase
    end

    assign o_data = r_data;

endmodule

// File: rtl/rotation_controller.sv
// Per-frame rotation matrix generator: steps an 8-bit angle from the keyboard on
// each vertical blank and commits a Q9.6 cos/sin matrix four edges later.
module rotation_controller
    import rot_pkg::*;
#(
    parameter int ANGLE_STEP = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [7:0]         keycode,
    output logic signed [15:0] m00,
    output logic signed [15:0] m01,
    output logic signed [15:0] m10,
    output logic signed [15:0] m11,
    output logic               mat_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [7:0] STEP = 8'(ANGLE_STEP);

    rot_state_t         r_state;
    rot_state_t         w_next_state;
    logic [7:0]         r_angle;
    logic signed [15:0] r_cos;
    logic signed [15:0] r_sin;
    logic signed [15:0] r_m00;
    logic signed [15:0] r_m01;
    logic signed [15:0] r_m10;
    logic signed [15:0] r_m11;
    logic               r_mat_valid;
    logic               r_overrun;
    logic               w_busy;
    logic [7:0]         w_cos_angle;
    logic [7:0]         w_rom_angle;
    logic [6:0]         w_rom_addr;
    logic [7:0]         w_rom_data;

    // Quadrants 1 and 3 mirror the table: index 64-i instead of i.
    function automatic logic [6:0] fold_addr(input logic [7:0] a);
        logic [6:0] i;
        i = {1'b0, a[5:0]};
        return a[6] ? 7'(7'd64 - i) : i;
    endfunction

    // Lower half-turn is negated; two's complement makes -0 collapse to 0.
    function automatic logic signed [15:0] apply_sign(input logic [7:0] mag, input logic neg);
        logic signed [15:0] v;
        v = signed'({8'd0, mag});
        return neg ? -v : v;
    endfunction

    assign w_busy      = (r_state != IDLE);
    assign w_cos_angle = r_angle + 8'd64;
    assign w_rom_angle = (r_state == ADDR_COS) ? w_cos_angle : r_angle;
    assign w_rom_addr  = fold_addr(w_rom_angle);

    sincos_rom u_rom (
        .i_clk  (Clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (frame_start) w_next_state = ADDR_COS;
            ADDR_COS: w_next_state = ADDR_SIN;
            ADDR_SIN: w_next_state = CAP_SIN;
            CAP_SIN:  w_next_state = COMMIT;
            COMMIT:   w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_angle     <= 8'd0;
            r_mat_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mat_valid <= (r_state == COMMIT);
            if (frame_start && w_busy) begin
                r_overrun <= 1'b1;
            end
            if (frame_start && !w_busy) begin
                if (keycode == KEY_CCW) begin
                    r_angle <= r_angle + STEP;
                end else if (keycode == KEY_CW) begin
                    r_angle <= r_angle - STEP;
                end
            end
        end
    end

    // ROM output lags its address by one edge, so each capture uses the angle
    // that produced the address in the previous state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cos <= 16'sd0;
            r_sin <= 16'sd0;
            r_m00 <= ONE;
            r_m01 <= 16'sd0;
            r_m10 <= 16'sd0;
            r_m11 <= ONE;
        end else begin
            if (r_state == ADDR_SIN) begin
                r_cos <= apply_sign(w_rom_data, w_cos_angle[7]);
            end
            if (r_state == CAP_SIN) begin
                r_sin <= apply_sign(w_rom_data, r_angle[7]);
            end
            if (r_state == COMMIT) begin
                r_m00 <= r_cos;
                r_m01 <= -r_sin;
                r_m10 <= r_sin;
                r_m11 <= r_cos;
            end
        end
    end

    assign m00       = r_m00;
    assign m01       = r_m01;
    assign m10       = r_m10;
    assign m11       = r_m11;
    assign mat_valid = r_mat_valid;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_rotation_controller.sv
// Directed bench for rotation_controller: a floating-point sine model fills a
// scoreboard at each frame_start and is compared when mat_valid pulses.
module tb_rotation_controller;

    localparam logic [63:0] IDENT = 64'h0040_0000_0000_0040;

    logic              Clk;
    logic              Reset_n;
    logic              frame_start;
    logic [7:0]        keycode;
    logic [15:0]       m00, m01, m10, m11;
    logic              mat_valid;
    logic              busy;
    logic              overrun;
    logic [63:0]       mat;

    int                n_checks;
    int                n_fail;
    int                angle;
    logic [63:0]       committed;
    logic [63:0]       exp_q[$];

    rotation_controller dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .keycode     (keycode),
        .m00         (m00),
        .m01         (m01),
        .m10         (m10),
        .m11         (m11),
        .mat_valid   (mat_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    assign mat = {m00, m01, m10, m11};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] sin_q6(input int a);
        real v;
        int  r;
        v = 64.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 256.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return 16'(r);
    endfunction

    function automatic logic [63:0] expected_mat(input int a);
        logic [15:0] s;
        logic [15:0] c;
        s = sin_q6(a);
        c = sin_q6((a + 64) % 256);
        return {c, 16'(16'd0 - s), s, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] key, input string tag);
        frame_start = 1'b1;
        keycode     = key;
        if (key == 8'h14)      angle = (angle + 1) % 256;
        else if (key == 8'h08) angle = (angle + 255) % 256;
        exp_q.push_back(expected_mat(angle));
        @(posedge Clk); #1;
        frame_start = 1'b0;
        keycode     = 8'h00;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_commit(input string tag, input int lat);
        int          cyc;
        bit          seen;
        logic [63:0] e;
        cyc  = 0;
        seen = 0;
        while (cyc < 12 && !seen) begin
            @(posedge Clk); #1;
            cyc++;
            if (mat_valid) seen = 1;
            else check({tag, "_hold"}, mat, committed);
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        if (seen) begin
            check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_mat"}, mat, e);
                committed = e;
            end
            @(posedge Clk); #1;
            check({tag, "_vld_off"}, {63'd0, mat_valid}, 64'd0);
            check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int pulses;
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge Clk); #1;
            if (mat_valid) pulses++;
        end
        check({tag, "_no_pulse"}, 64'(pulses), 64'd0);
        check({tag, "_mat"}, mat, committed);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        angle       = 0;
        committed   = IDENT;
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        keycode     = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_mat", mat, IDENT);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_vld", {63'd0, mat_valid}, 64'd0);
        check("reset_ovr", {63'd0, overrun}, 64'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        start_frame(8'h00, "ident");
        wait_commit("ident", 4);
        check("ident_const", mat, 64'h0040_0000_0000_0040);

        start_frame(8'h14, "ang1");
        wait_commit("ang1", 4);
        check("ang1_const", mat, 64'h0040_FFFE_0002_0040);

        for (int f = 0; f < 63; f++) begin
            start_frame(8'h14, "sweep");
            wait_commit("sweep", 4);
        end
        check("ang64_const", mat, 64'h0000_FFC0_0040_0000);
        check("ang64_ovr", {63'd0, overrun}, 64'd0);

        start_frame(8'h14, "ovr");
        @(posedge Clk); #1;
        check("ovr_hold_e1", mat, committed);
        frame_start = 1'b1;
        keycode     = 8'h14;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        keycode     = 8'h00;
        check("ovr_hold_e2", mat, committed);
        wait_commit("ovr", 2);
        check("ovr_flag", {63'd0, overrun}, 64'd1);
        quiet("ovr_after", 8);
        check("ovr_sb_empty", 64'(exp_q.size()), 64'd0);
        check("ovr_flag_sticky", {63'd0, overrun}, 64'd1);

        start_frame(8'h14, "rst");
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        angle     = 0;
        committed = IDENT;
        exp_q.delete();
        check("rst_mid_mat", mat, IDENT);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_vld", {63'd0, mat_valid}, 64'd0);
        check("rst_mid_ovr", {63'd0, overrun}, 64'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        quiet("rst_after", 8);
        check("rst_after_busy", {63'd0, busy}, 64'd0);

        start_frame(8'h00, "resume");
        wait_commit("resume", 4);
        check("resume_const", mat, IDENT);

        start_frame(8'h08, "wrap");
        wait_commit("wrap", 4);
        check("wrap_const", mat, 64'h0040_0002_FFFE_0040);

        start_frame(8'h08, "ang254");
        wait_commit("ang254", 4);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
